blake2_msg_sender: RTL

- Host-side initiator for the blake2 byte-serial core. Takes an upstream message byte stream and turns it into the core's block protocol: data_v/data_idx/data bytes, block_first/block_last flags, ll byte count, kk/nn.
- Zero-pads the final block to BLOCK_BYTES.
- Captures the core's h_v/h byte output and re-emits it as a clean nn-byte stream with a last flag.

---
 rtl/blake2_pkg.sv | 28 ++
 rtl/blake2_hash_capture.sv | 59 +++++
 rtl/blake2_msg_sender.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// Shared types and constants for the blake2 host-side message sender.
// Holds the sender FSM encoding, block geometry, config widths and pad byte.
// Optional macro BLAKE2_SLOW_OUT_EN selects the core's slow (2-cycle) hash output mode.
package blake2_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         IDX_W       = $clog2(BLOCK_BYTES);
    localparam int         LL_W        = 64;
    localparam int         CFG_W       = 7;
    localparam logic [7:0] PAD_BYTE    = 8'h00;

`ifdef BLAKE2_SLOW_OUT_EN
    // Core holds each hash byte for two cycles after a two-cycle preamble.
    localparam bit SLOW_OUT = 1'b1;
    localparam int PRE      = 2;
`else
    localparam bit SLOW_OUT = 1'b0;
    localparam int PRE      = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_PAD    = 2'd2,
        S_HASH   = 2'd3
    } state_e;

endpackage

// File: rtl/blake2_hash_capture.sv
// Turns the core's h_v/h byte window into a clean nn-byte stream with a last flag.
// Ports: clk/rst, en_i (sender in hash phase), nn_i, core h_v_i/h_i in; out_v_o/out_byte_o/out_last_o out.
// Combinational from h_v_i (zero latency); no backpressure. Slow mode via BLAKE2_SLOW_OUT_EN.
module blake2_hash_capture
    import blake2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CFG_W-1:0] nn_i,
    input  logic             h_v_i,
    input  logic [7:0]       h_i,
    output logic             out_v_o,
    output logic [7:0]       out_byte_o,
    output logic             out_last_o
);

    // Enough for PRE + 2*64 h_v cycles.
    localparam int CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] post;
    logic [CNT_W-1:0] byte_n;
    logic             in_data;
    logic             capture;

    always_comb begin
        post    = cnt_q - CNT_W'(PRE);
        in_data = (cnt_q >= CNT_W'(PRE));
        // In slow mode each byte spans two h_v cycles; take it on the second one.
        if (SLOW_OUT) begin
            capture = in_data & post[0];
            byte_n  = post >> 1;
        end else begin
            capture = in_data;
            byte_n  = post;
        end

        out_v_o    = en_i & h_v_i & capture;
        out_byte_o = out_v_o ? h_i : 8'h00;
        out_last_o = out_v_o & (byte_n == (CNT_W'(nn_i) - CNT_W'(1)));

        cnt_d = cnt_q;
        if (!en_i || out_last_o) begin
            cnt_d = '0;
        end else if (h_v_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blake2_msg_sender.sv
// Host-side initiator: byte stream in -> blake2 core block protocol out, zero-padding the final block;
// captures the core hash and re-emits it as nn bytes. Ports: upstream in_*, core_* to/from the core, out_* hash, busy_o.
// One-byte lookahead (hold) so the final byte always carries block_last; core_data_v_o only when core_ready_i.
// Optional macro BLAKE2_SLOW_OUT_EN: core slow output mode (2-cycle preamble, each hash byte held 2 cycles).
module blake2_msg_sender
    import blake2_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CFG_W-1:0] kk_i,
    input  logic [CFG_W-1:0] nn_i,
    input  logic             in_v_i,
    output logic             in_ready_o,
    input  logic             in_keep_i,
    input  logic             in_last_i,
    input  logic [7:0]       in_byte_i,
    input  logic             core_ready_i,
    output logic             core_data_v_o,
    output logic [IDX_W-1:0] core_data_idx_o,
    output logic [7:0]       core_data_o,
    output logic             core_first_o,
    output logic             core_last_o,
    output logic [127:0]     core_ll_o,
    output logic [CFG_W-1:0] core_kk_o,
    output logic [CFG_W-1:0] core_nn_o,
    output logic             core_slow_o,
    input  logic             core_h_v_i,
    input  logic [7:0]       core_h_i,
    output logic             out_v_o,
    output logic [7:0]       out_byte_o,
    output logic             out_last_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             hold_v_q, hold_v_d;
    logic [7:0]       hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic [LL_W-1:0]  ll_q, ll_d;
    logic [CFG_W-1:0] kk_q, kk_d;
    logic [CFG_W-1:0] nn_q, nn_d;

    logic             idx_last;
    logic [IDX_W-1:0] idx_nxt;
    logic [LL_W-1:0]  ll_inc;
    logic             cap_last;

    always_comb begin
        state_d  = state_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        first_d  = first_q;
        ll_d     = ll_q;
        kk_d     = kk_q;
        nn_d     = nn_q;

        in_ready_o      = 1'b0;
        core_data_v_o   = 1'b0;
        core_data_o     = hold_v_q ? hold_q : PAD_BYTE;
        core_data_idx_o = idx_q;
        core_first_o    = first_q;
        core_last_o     = 1'b0;

        idx_last = (idx_q == IDX_W'(BLOCK_BYTES - 1));
        idx_nxt  = idx_last ? '0 : idx_q + IDX_W'(1);
        ll_inc   = (ll_q == '1) ? ll_q : ll_q + LL_W'(1);

        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_v_i && (in_keep_i || in_last_i)) begin
                    kk_d     = kk_i;
                    nn_d     = nn_i;
                    first_d  = 1'b1;
                    idx_d    = '0;
                    hold_d   = in_byte_i;
                    hold_v_d = in_keep_i;
                    ll_d     = LL_W'(in_keep_i);
                    state_d  = in_last_i ? S_PAD : S_STREAM;
                end
            end

            S_STREAM: begin
                in_ready_o = core_ready_i;
                if (in_v_i && core_ready_i) begin
                    core_data_v_o = 1'b1;
                    // A final beat that carries a byte into the next block leaves this block not-last.
                    core_last_o   = in_last_i & ~(in_keep_i & idx_last);
                    hold_d        = in_byte_i;
                    hold_v_d      = in_keep_i;
                    idx_d         = idx_nxt;
                    if (in_keep_i) begin
                        ll_d = ll_inc;
                    end
                    if (idx_last) begin
                        first_d = 1'b0;
                    end
                    if (in_last_i) begin
                        // Terminator exactly at block end: nothing left to pad.
                        state_d = (!in_keep_i && idx_last) ? S_HASH : S_PAD;
                    end
                end
            end

            S_PAD: begin
                if (core_ready_i) begin
                    core_data_v_o = 1'b1;
                    core_last_o   = 1'b1;
                    hold_v_d      = 1'b0;
                    idx_d         = idx_nxt;
                    if (idx_last) begin
                        first_d = 1'b0;
                        state_d = S_HASH;
                    end
                end
            end

            S_HASH: begin
                if (cap_last) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            idx_q    <= '0;
            first_q  <= 1'b0;
            ll_q     <= '0;
            kk_q     <= '0;
            nn_q     <= '0;
        end else begin
            state_q  <= state_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            ll_q     <= ll_d;
            kk_q     <= kk_d;
            nn_q     <= nn_d;
        end
    end

    blake2_hash_capture u_cap (
        .clk        (clk),
        .rst        (reset),
        .en_i       (state_q == S_HASH),
        .nn_i       (nn_q),
        .h_v_i      (core_h_v_i),
        .h_i        (core_h_i),
        .out_v_o    (out_v_o),
        .out_byte_o (out_byte_o),
        .out_last_o (cap_last)
    );

    assign out_last_o  = cap_last;
    assign core_ll_o   = 128'(ll_q);
    assign core_kk_o   = kk_q;
    assign core_nn_o   = nn_q;
    assign core_slow_o = SLOW_OUT;
    assign busy_o      = (state_q != S_IDLE);

endmodule
